// File: rtl/duty_phase_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : duty_phase_loader
// Description : Loads one frame of per-transducer {duty, phase} targets from
//               the gain BRAM into shadow arrays, then commits all of them to
//               DUTY/PHASE on a single clock edge and pulses START for one
//               cycle so the downstream low-pass filter latches a consistent
//               frame.
//
// Ports
//   CLK        in   system clock
//   RST        in   synchronous reset, active-high
//   UPDATE     in   load request, sampled every cycle
//   FRAME_IDX  in   frame to load, sampled with UPDATE
//   CYCLE      in   per-transducer period (clamp build only)
//   BRAM_EN    out  BRAM read enable
//   BRAM_ADDR  out  {frame, transducer index}
//   BRAM_DOUT  in   {duty[2W-1:W], phase[W-1:0]}
//   DUTY       out  committed duty targets
//   PHASE      out  committed phase targets
//   START      out  one-cycle commit strobe
//   BUSY       out  high whenever the loader is not idle
//
// Build option
//   LOADER_CLAMP_EN : when defined, each captured word is clamped against
//                     CYCLE[k] on the capture path (duty saturates to the
//                     period, phase wraps once by the period).
//
// Revision    : 1.0 - initial release
// ============================================================================
module duty_phase_loader #(
    parameter int WIDTH      = 13,
    parameter int DEPTH      = 249,
    parameter int FRAME_W    = 8,
    parameter int TR_W       = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          UPDATE,
    input  logic [FRAME_W-1:0]            FRAME_IDX,
    input  logic [DEPTH-1:0][WIDTH-1:0]   CYCLE,
    output logic                          BRAM_EN,
    output logic [FRAME_W+TR_W-1:0]       BRAM_ADDR,
    input  logic [2*WIDTH-1:0]            BRAM_DOUT,
    output logic [DEPTH-1:0][WIDTH-1:0]   DUTY,
    output logic [DEPTH-1:0][WIDTH-1:0]   PHASE,
    output logic                          START,
    output logic                          BUSY
);

    localparam logic [TR_W-1:0] LAST_IDX = TR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        DRAIN  = 3'd2,
        COMMIT = 3'd3,
        STROBE = 3'd4
    } state_t;

    state_t                     state;
    state_t                     next_state;

    logic [FRAME_W-1:0]         frame;
    logic [FRAME_W-1:0]         pend_frame;
    logic                       pending;
    logic [TR_W-1:0]            addr_cnt;
    logic [TR_W-1:0]            cap_cnt;
    logic [RD_LATENCY-1:0]      rd_pipe;
    logic                       capture;

    logic [DEPTH-1:0][WIDTH-1:0] shadow_duty;
    logic [DEPTH-1:0][WIDTH-1:0] shadow_phase;

    logic [WIDTH-1:0]           raw_duty;
    logic [WIDTH-1:0]           raw_phase;
    logic [WIDTH-1:0]           cap_duty;
    logic [WIDTH-1:0]           cap_phase;

    // ------------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (UPDATE || pending)                   next_state = READ;
            READ:    if (addr_cnt == LAST_IDX)                next_state = DRAIN;
            DRAIN:   if (capture && (cap_cnt == LAST_IDX))   next_state = COMMIT;
            COMMIT:                                           next_state = STROBE;
            STROBE:                                           next_state = IDLE;
            default:                                          next_state = IDLE;
        endcase
    end

    assign BRAM_EN   = (state == READ);
    assign BRAM_ADDR = BRAM_EN ? {frame, addr_cnt} : '0;
    assign START     = (state == STROBE);
    assign BUSY      = (state != IDLE);

    // A word arrives exactly RD_LATENCY edges after the BRAM samples its
    // address, so a copy of BRAM_EN delayed by that many stages marks the
    // capture cycle. The capture counter follows this strobe on its own and
    // does not look at the address counter.
    assign capture = rd_pipe[RD_LATENCY-1];

    // ------------------------------------------------------------------------
    // Request latching, counters and commit
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame      <= '0;
            pend_frame <= '0;
            pending    <= 1'b0;
            addr_cnt   <= '0;
            cap_cnt    <= '0;
            rd_pipe    <= '0;
            DUTY       <= '0;
            PHASE      <= '0;
        end else begin
            rd_pipe[0] <= BRAM_EN;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end

            if (state == IDLE) begin
                addr_cnt <= '0;
                cap_cnt  <= '0;
                // A live request overrides a queued one: latest request wins.
                if (UPDATE) begin
                    frame   <= FRAME_IDX;
                    pending <= 1'b0;
                end else if (pending) begin
                    frame   <= pend_frame;
                    pending <= 1'b0;
                end
            end else if (UPDATE) begin
                pending    <= 1'b1;
                pend_frame <= FRAME_IDX;
            end

            if ((state == READ) && (addr_cnt != LAST_IDX)) begin
                addr_cnt <= addr_cnt + 1'b1;
            end

            if (capture && (cap_cnt != LAST_IDX)) begin
                cap_cnt <= cap_cnt + 1'b1;
            end

            if (state == COMMIT) begin
                DUTY  <= shadow_duty;
                PHASE <= shadow_phase;
            end
        end
    end

    // Shadow storage is never visible directly, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (capture) begin
            shadow_duty[cap_cnt]  <= cap_duty;
            shadow_phase[cap_cnt] <= cap_phase;
        end
    end

    // ------------------------------------------------------------------------
    // Capture path
    // ------------------------------------------------------------------------
    assign raw_duty  = BRAM_DOUT[2*WIDTH-1:WIDTH];
    assign raw_phase = BRAM_DOUT[WIDTH-1:0];

`ifdef LOADER_CLAMP_EN
    logic [WIDTH-1:0] cyc_k;
    logic [WIDTH:0]   phase_diff;

    assign cyc_k      = CYCLE[cap_cnt];
    // One extended subtraction; a clear borrow bit means phase >= period.
    assign phase_diff = {1'b0, raw_phase} - {1'b0, cyc_k};

    always_comb begin
        cap_duty  = raw_duty;
        cap_phase = raw_phase;
        if (raw_duty > cyc_k) begin
            cap_duty = cyc_k;
        end
        if (!phase_diff[WIDTH]) begin
            cap_phase = phase_diff[WIDTH-1:0];
        end
    end
`else
    logic unused_cycle;

    assign cap_duty     = raw_duty;
    assign cap_phase    = raw_phase;
    assign unused_cycle = ^CYCLE;
`endif

endmodule
`default_nettype wire
